// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch front end.
package fetch_pkg;
    localparam int          PC_W      = 16;
    localparam logic [4:0]  OP_HALT   = 5'b00000;
    localparam logic [4:0]  OP_NOP    = 5'b00001;
    localparam logic [15:0] NOP_INSTR = {OP_NOP, 11'b000_0000_0000};

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_SQUASH = 2'd1,
        S_HALT   = 2'd2
    } state_t;
endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter with sequential increment, redirect load and a latch
// holding the address of the request that is still in flight.
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
    parameter logic [PC_W-1:0] PC_INC   = 16'd2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_advance,
    input  logic            i_load,
    input  logic [PC_W-1:0] i_load_pc,
    input  logic            i_track,
    input  logic            i_use_latch,
    output logic [PC_W-1:0] o_pc_next,
    output logic [PC_W-1:0] o_addr
);
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_addr_latch;
    logic [PC_W-1:0] w_pc_next;

    // Natural 16-bit overflow gives the required modulo-2^16 wrap.
    assign w_pc_next = r_pc + PC_INC;
    assign o_pc_next = w_pc_next;
    assign o_addr    = i_use_latch ? r_addr_latch : r_pc;

    // PC update: a redirect target takes priority over sequential advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= i_load_pc;
        end else if (i_advance) begin
            r_pc <= w_pc_next;
        end
    end

    // Latch follows the PC while fetching, then freezes so a squashed request keeps its address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr_latch <= RESET_PC;
        end else if (i_track) begin
            r_addr_latch <= r_pc;
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, runs the imem req/done handshake,
// presents one held instruction to decode and handles redirects and HALT.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
    parameter logic [PC_W-1:0] PC_INC   = 16'd2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_rdata,
    input  logic            imem_done,
    input  logic            imem_err,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            stall,
    output logic            instr_valid,
    output logic [15:0]     instr,
    output logic [4:0]      opcode,
    output logic [1:0]      funct,
    output logic [PC_W-1:0] pc_plus,
    output logic            halted,
    output logic            err
);
    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_valid;
    logic            r_err;
    logic [15:0]     r_instr;
    logic [PC_W-1:0] r_pc_plus;

    logic            w_req;
    logic            w_done;
    logic            w_consume;
    logic            w_redir_en;
    logic            w_misalign;
    logic            w_redir;
    logic            w_fetch_ok;
    logic            w_fetch_err;
    logic            w_fault;
    logic            w_is_halt;
    logic [PC_W-1:0] w_pc_next;
    logic [PC_W-1:0] w_addr;

    assign w_consume   = r_valid & ~stall;
    assign w_done      = imem_done & w_req;
    // Redirects from execute are meaningless once fetch has stopped.
    assign w_redir_en  = redirect & (r_state != S_HALT);
    assign w_misalign  = w_redir_en & redirect_pc[0];
    assign w_redir     = w_redir_en & ~redirect_pc[0];
    // Data returning in a redirect cycle is wrong-path and never used.
    assign w_fetch_ok  = (r_state == S_FETCH) & w_done & ~imem_err & ~redirect;
    assign w_fetch_err = (r_state == S_FETCH) & w_done & imem_err & ~redirect;
    assign w_fault     = w_misalign | w_fetch_err;
    assign w_is_halt   = (imem_rdata[15:11] == OP_HALT);

    fetch_pc_reg #(
        .RESET_PC (RESET_PC),
        .PC_INC   (PC_INC)
    ) u_pc (
        .clk         (clk),
        .rst         (rst),
        .i_advance   (w_fetch_ok),
        .i_load      (w_redir),
        .i_load_pc   (redirect_pc),
        .i_track     (r_state == S_FETCH),
        .i_use_latch (r_state == S_SQUASH),
        .o_pc_next   (w_pc_next),
        .o_addr      (w_addr)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: faults stop fetch; a redirect with a request still in flight must drain it first.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FETCH: begin
                if (w_fault) begin
                    w_state_nxt = S_HALT;
                end else if (w_redir) begin
                    if (w_req & ~w_done) begin
                        w_state_nxt = S_SQUASH;
                    end
                end else if (w_fetch_ok & w_is_halt) begin
                    w_state_nxt = S_HALT;
                end
            end
            S_SQUASH: begin
                if (w_fault) begin
                    w_state_nxt = S_HALT;
                end else if (w_done) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_HALT:  w_state_nxt = S_HALT;
            default: w_state_nxt = S_FETCH;
        endcase
    end

    // Request: no new fetch while a stalled instruction is held; reset drops any request at once.
    always_comb begin
        w_req = 1'b0;
        if (!rst) begin
            case (r_state)
                S_FETCH:  w_req = ~r_valid | ~stall;
                S_SQUASH: w_req = 1'b1;
                default:  w_req = 1'b0;
            endcase
        end
    end

    // Output register: fault, then redirect squash, then new fetch, then plain consume.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_instr   <= NOP_INSTR;
            r_pc_plus <= '0;
            r_err     <= 1'b0;
        end else if (w_fault) begin
            r_valid <= 1'b0;
            r_err   <= 1'b1;
        end else if (w_redir) begin
            r_valid <= 1'b0;
        end else if (w_fetch_ok) begin
            r_instr   <= imem_rdata;
            r_valid   <= 1'b1;
            r_pc_plus <= w_pc_next;
        end else if (w_consume) begin
            r_valid <= 1'b0;
        end
    end

    assign imem_req    = w_req;
    assign imem_addr   = w_addr;
    assign instr_valid = r_valid;
    assign instr       = r_instr;
    assign opcode      = r_instr[15:11];
    assign funct       = r_instr[1:0];
    assign pc_plus     = r_pc_plus;
    assign err         = r_err;
    assign halted      = (r_state == S_HALT) & ~r_valid;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory model with configurable latency, directed
// scenarios, and a randomized run checked by an in-order stream scoreboard.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_done;
    logic        imem_err;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        stall = 1'b0;
    logic        instr_valid;
    logic [15:0] instr;
    logic [4:0]  opcode;
    logic [1:0]  funct;
    logic [15:0] pc_plus;
    logic        halted;
    logic        err;

    fetch_unit #(.RESET_PC(16'h0000), .PC_INC(16'd2)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .imem_done(imem_done), .imem_err(imem_err),
        .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
        .instr_valid(instr_valid), .instr(instr), .opcode(opcode), .funct(funct),
        .pc_plus(pc_plus), .halted(halted), .err(err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Memory image indexed by word address, plus per-word fault flags.
    logic [15:0] mem [0:32767];
    bit          merr [0:32767];
    int          lat = 0;
    bit          rand_lat = 1'b0;
    int          wcnt = 0;
    bit          pend = 1'b0;
    logic [15:0] paddr = 16'h0000;

    // Expected delivered-instruction stream.
    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pcp;
    } exp_t;
    exp_t        exp_q[$];
    exp_t        mon_e;
    bit          sb_en = 1'b0;
    int          sb_pops = 0;
    logic [15:0] model_pc;

    logic [4:0]  vpat;
    logic        h3, h4, r4;

    // Memory bookkeeping at mid-cycle: wait counter and address stability of a pending request.
    initial begin
        forever begin
            @(negedge clk);
            if (pend && imem_req && !rst) begin
                vectors++;
                if (imem_addr !== paddr) begin
                    miscompares++;
                    $display("FAIL addr_stable: imem_addr=%h while request to %h outstanding", imem_addr, paddr);
                end
            end
            if (rst || !imem_req || imem_done) begin
                wcnt = 0;
                pend = 1'b0;
                if (rand_lat) lat = $urandom_range(0, 2);
            end else begin
                wcnt++;
                pend  = 1'b1;
                paddr = imem_addr;
            end
        end
    end

    // Memory response, driven shortly after each rising edge once the request is settled.
    initial begin
        imem_done  = 1'b0;
        imem_err   = 1'b0;
        imem_rdata = 16'h0000;
        forever begin
            @(posedge clk);
            #2;
            if (imem_req && wcnt >= lat) begin
                imem_done  = 1'b1;
                imem_rdata = mem[imem_addr[15:1]];
                imem_err   = merr[imem_addr[15:1]];
            end else begin
                imem_done  = 1'b0;
                imem_rdata = 16'($urandom);
                imem_err   = 1'($urandom);
            end
        end
    end

    // Scoreboard monitor: every handshake not cancelled by a redirect delivers the next expected word.
    initial begin
        forever begin
            @(negedge clk);
            if (sb_en && !rst && instr_valid && !stall && !redirect) begin
                vectors++;
                sb_pops++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL sb_extra: got instr=%h pc_plus=%h, expected no instruction", instr, pc_plus);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (instr !== mon_e.instr || pc_plus !== mon_e.pcp ||
                        opcode !== mon_e.instr[15:11] || funct !== mon_e.instr[1:0]) begin
                        miscompares++;
                        $display("FAIL sb_instr: got instr=%h pc_plus=%h op=%b fn=%b, expected instr=%h pc_plus=%h",
                                 instr, pc_plus, opcode, funct, mon_e.instr, mon_e.pcp);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected normal completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fill_default();
        for (int i = 0; i < 32768; i++) begin
            logic [15:0] w;
            w = 16'((i * 40503 + 12345) >> 3);
            if (w[15:11] == 5'b00000) w[15:11] = 5'b00001;
            mem[i]  = w;
            merr[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        stall       = 1'b0;
        sb_en       = 1'b0;
        rand_lat    = 1'b0;
        lat         = 0;
        step();
        step();
        fill_default();
    endtask

    task automatic release_rst();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int bound);
        int n = 0;
        while (!instr_valid && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (!instr_valid) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: instr_valid still 0 after %0d cycles, expected 1", name, bound);
        end
    endtask

    task automatic refill();
        while (exp_q.size() < 4) begin
            exp_q.push_back('{instr: mem[model_pc[15:1]], pcp: model_pc + 16'd2});
            model_pc = model_pc + 16'd2;
        end
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_valid", instr_valid, 1'b0);
        check("rst_instr", instr, 16'h0800);
        check("rst_opcode", opcode, 5'b00001);
        check("rst_pc_plus", pc_plus, 16'h0000);
        check("rst_halted", halted, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_req", imem_req, 1'b0);

        // Straight-line program ending in HALT, single-cycle memory
        do_reset();
        mem[0] = 16'h4000;
        mem[1] = 16'h4100;
        mem[2] = 16'h0000;
        exp_q.delete();
        exp_q.push_back('{instr: 16'h4000, pcp: 16'h0002});
        exp_q.push_back('{instr: 16'h4100, pcp: 16'h0004});
        exp_q.push_back('{instr: 16'h0000, pcp: 16'h0006});
        sb_en = 1'b1;
        release_rst();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            vpat[4-k] = instr_valid;
            if (k == 3) h3 = halted;
            if (k == 4) begin
                h4 = halted;
                r4 = imem_req;
            end
        end
        sb_en = 1'b0;
        check("halt_valid_pattern", vpat, 5'b01110);
        check("halt_not_yet", h3, 1'b0);
        check("halt_halted", h4, 1'b1);
        check("halt_req_low", r4, 1'b0);
        check("halt_stream_done", exp_q.size(), 0);
        step();
        @(negedge clk);
        check("halt_req_stays_low", imem_req, 1'b0);

        // Stall holds the output register and suppresses requests
        do_reset();
        mem[0] = 16'h4000;
        mem[1] = 16'h4800;
        stall  = 1'b1;
        release_rst();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_instr", instr, 16'h4000);
            check("stall_valid", instr_valid, 1'b1);
            check("stall_req", imem_req, 1'b0);
            check("stall_addr", imem_addr, 16'h0002);
        end
        step();
        stall = 1'b0;
        @(negedge clk);
        check("unstall_req", imem_req, 1'b1);
        check("unstall_addr", imem_addr, 16'h0002);
        @(negedge clk);
        check("unstall_instr", instr, 16'h4800);
        check("unstall_opcode", opcode, 5'b01001);
        check("unstall_pc_plus", pc_plus, 16'h0004);

        // Redirect during a slow fetch squashes the in-flight request
        do_reset();
        mem[0] = 16'h4000;
        mem[8] = 16'h5000;
        lat    = 3;
        release_rst();
        @(negedge clk);
        check("sq_req0", imem_req, 1'b1);
        check("sq_addr0", imem_addr, 16'h0000);
        step();
        redirect    = 1'b1;
        redirect_pc = 16'h0010;
        step();
        redirect = 1'b0;
        @(negedge clk);
        check("sq_hold_req", imem_req, 1'b1);
        check("sq_hold_addr", imem_addr, 16'h0000);
        check("sq_hold_valid", instr_valid, 1'b0);
        step();
        @(negedge clk);
        check("sq_drop_valid", instr_valid, 1'b0);
        step();
        @(negedge clk);
        check("sq_target_addr", imem_addr, 16'h0010);
        check("sq_target_req", imem_req, 1'b1);
        check("sq_target_valid", instr_valid, 1'b0);
        wait_valid("sq_target_fetch", 20);
        check("sq_target_instr", instr, 16'h5000);
        check("sq_target_pc_plus", pc_plus, 16'h0012);

        // Misaligned redirect is a fault; later redirects are ignored
        do_reset();
        release_rst();
        step();
        step();
        redirect    = 1'b1;
        redirect_pc = 16'h0013;
        step();
        redirect = 1'b0;
        @(negedge clk);
        check("mis_err", err, 1'b1);
        check("mis_valid", instr_valid, 1'b0);
        check("mis_halted", halted, 1'b1);
        check("mis_req", imem_req, 1'b0);
        step();
        redirect    = 1'b1;
        redirect_pc = 16'h0020;
        step();
        redirect = 1'b0;
        @(negedge clk);
        check("mis_ignore_req", imem_req, 1'b0);
        check("mis_ignore_valid", instr_valid, 1'b0);
        check("mis_sticky_err", err, 1'b1);
        check("mis_still_halted", halted, 1'b1);

        // PC wrap at the top of the address space
        do_reset();
        mem[32767] = 16'h4123;
        release_rst();
        redirect    = 1'b1;
        redirect_pc = 16'hFFFE;
        step();
        redirect = 1'b0;
        @(negedge clk);
        check("wrap_addr", imem_addr, 16'hFFFE);
        check("wrap_req", imem_req, 1'b1);
        @(negedge clk);
        check("wrap_instr", instr, 16'h4123);
        check("wrap_pc_plus", pc_plus, 16'h0000);
        check("wrap_next_addr", imem_addr, 16'h0000);
        check("wrap_err", err, 1'b0);

        // Fault reported by memory on a live fetch
        do_reset();
        merr[1] = 1'b1;
        release_rst();
        @(negedge clk);
        @(negedge clk);
        check("ferr_before", err, 1'b0);
        @(negedge clk);
        check("ferr_err", err, 1'b1);
        check("ferr_halted", halted, 1'b1);
        check("ferr_valid", instr_valid, 1'b0);
        check("ferr_req", imem_req, 1'b0);

        // Asynchronous reset in the middle of an outstanding request
        do_reset();
        stall = 1'b1;
        release_rst();
        step();
        lat   = 3;
        stall = 1'b0;
        @(negedge clk);
        check("arst_pending_req", imem_req, 1'b1);
        @(posedge clk);
        #4;
        rst = 1'b1;
        #1;
        check("arst_req", imem_req, 1'b0);
        check("arst_valid", instr_valid, 1'b0);
        check("arst_instr", instr, 16'h0800);
        lat = 0;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("arst_first_req", imem_req, 1'b1);
        check("arst_first_addr", imem_addr, 16'h0000);

        // Randomized stall, latency and redirects against the stream model
        do_reset();
        rand_lat = 1'b1;
        exp_q.delete();
        model_pc = 16'h0000;
        refill();
        sb_en   = 1'b1;
        sb_pops = 0;
        release_rst();
        for (int c = 0; c < 4000; c++) begin
            step();
            stall = ($urandom_range(0, 9) < 3);
            if ($urandom_range(0, 19) == 0) begin
                redirect    = 1'b1;
                redirect_pc = 16'($urandom_range(0, 32767) * 2);
                exp_q.delete();
                model_pc = redirect_pc;
            end else begin
                redirect = 1'b0;
            end
            refill();
        end
        step();
        redirect = 1'b0;
        stall    = 1'b0;
        step();
        sb_en = 1'b0;
        check("rand_activity", (sb_pops >= 200), 1'b1);
        check("rand_no_err", err, 1'b0);
        check("rand_not_halted", halted, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
